// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the in-order pipeline: datapath width, base opcodes
// and the decode-stage sequencer states.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP        = 7'b0110011;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } id_state_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended RV32 immediate selected by opcode format.
// Opcodes without an immediate (register-register, unknown) yield zero.
module imm_gen
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] i_instr,
   output logic [XLEN-1:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (i_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR:
            o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         OP_STORE:
            o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         OP_BRANCH:
            o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            o_imm = {i_instr[31:12], 12'b0};
         OP_JAL:
            o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default:
            o_imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: IF/ID holding register, load-use interlock with a
// programmable bubble count, flush handling and the registered ID/EX bundle.
module id_stage_ctrl
   import riscv_pkg::*;
#(
   parameter int LU_BUBBLES = 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_instr,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic            ex_is_load
);

   localparam logic [1:0] LU_CNT_INIT = 2'(LU_BUBBLES - 1);

   // Which source registers an opcode reads: {rs1, rs2}.
   function automatic logic [1:0] regUse(input logic [6:0] op);
      case (op)
         OP_JALR, OP_LOAD, OP_IMM: regUse = 2'b10;
         OP, OP_STORE, OP_BRANCH:  regUse = 2'b11;
         default:                  regUse = 2'b00;
      endcase
   endfunction

   id_state_t       r_state;
   id_state_t       w_nextState;
   logic [1:0]      r_cnt;
   logic [1:0]      w_nextCnt;
   logic            w_issue;

   logic            r_idValid;
   logic [XLEN-1:0] r_idInstr;
   logic [XLEN-1:0] r_idPc;

   logic            r_exValid;
   logic [XLEN-1:0] r_exInstr;
   logic [XLEN-1:0] r_exPc;
   logic [XLEN-1:0] r_exImm;
   logic [4:0]      r_exRs1;
   logic [4:0]      r_exRs2;
   logic [4:0]      r_exRd;
   logic            r_exIsLoad;

   logic [XLEN-1:0] w_idImm;
   logic [1:0]      w_useRs;
   logic            w_advEx;
   logic            w_hazard;
   logic            w_ifReady;

   imm_gen u_immGen (
      .i_instr (r_idInstr),
      .o_imm   (w_idImm)
   );

   assign w_useRs  = regUse(r_idInstr[6:0]);
   assign w_advEx  = !r_exValid || ex_ready;
   assign w_hazard = (r_state == RUN) && r_idValid && r_exValid && r_exIsLoad &&
                     (r_exRd != 5'd0) &&
                     ((w_useRs[1] && (r_idInstr[19:15] == r_exRd)) ||
                      (w_useRs[0] && (r_idInstr[24:20] == r_exRd)));
   assign w_ifReady = !r_idValid || (w_advEx && (r_state == RUN) && !w_hazard);

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_issue     = 1'b0;
      case (r_state)
         RUN: begin
            if (w_advEx && r_idValid) begin
               if (w_hazard) begin
                  w_nextCnt   = LU_CNT_INIT;
                  w_nextState = (LU_CNT_INIT != 2'd0) ? LU_STALL : RUN;
               end else begin
                  w_issue = 1'b1;
               end
            end
         end
         LU_STALL: begin
            if (w_advEx) begin
               if (r_cnt != 2'd0) begin
                  w_nextCnt = r_cnt - 2'd1;
               end else begin
                  w_issue     = 1'b1;
                  w_nextState = RUN;
               end
            end
         end
         default: w_nextState = RUN;
      endcase
      if (flush) begin
         w_nextState = RUN;
         w_nextCnt   = '0;
         w_issue     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // ID accepts on the same edge it issues, so streaming needs no bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idValid <= 1'b0;
         r_idInstr <= '0;
         r_idPc    <= '0;
      end else if (flush) begin
         r_idValid <= 1'b0;
      end else if (if_valid && w_ifReady) begin
         r_idValid <= 1'b1;
         r_idInstr <= if_instr;
         r_idPc    <= if_pc;
      end else if (w_issue) begin
         r_idValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exValid  <= 1'b0;
         r_exInstr  <= '0;
         r_exPc     <= '0;
         r_exImm    <= '0;
         r_exRs1    <= '0;
         r_exRs2    <= '0;
         r_exRd     <= '0;
         r_exIsLoad <= 1'b0;
      end else if (flush) begin
         r_exValid <= 1'b0;
      end else if (w_advEx) begin
         r_exValid <= w_issue;
         if (w_issue) begin
            r_exInstr  <= r_idInstr;
            r_exPc     <= r_idPc;
            r_exImm    <= w_idImm;
            r_exRs1    <= r_idInstr[19:15];
            r_exRs2    <= r_idInstr[24:20];
            r_exRd     <= r_idInstr[11:7];
            r_exIsLoad <= (r_idInstr[6:0] == OP_LOAD);
         end
      end
   end

   assign if_ready   = w_ifReady;
   assign ex_valid   = r_exValid;
   assign ex_instr   = r_exInstr;
   assign ex_pc      = r_exPc;
   assign ex_imm     = r_exImm;
   assign ex_rs1     = r_exRs1;
   assign ex_rs2     = r_exRs2;
   assign ex_rd      = r_exRd;
   assign ex_is_load = r_exIsLoad;

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage sequencer: holds one fetched instruction (IF/ID), drives it through the existing imm_gen, and issues a registered ID/EX bundle to execute over a valid/ready handshake.
- Owns load-use interlock (programmable bubble count) and branch/jump flush.
- Sits between fetch and execute in the in-order pipeline.

Parameters:
- XLEN, 32, datapath/instruction/PC width (from riscv_pkg).
- LU_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents instruction.
- if_ready  out  1  ID accepts instruction this cycle.
- if_instr  in  XLEN  fetched instruction.
- if_pc  in  XLEN  its PC.
- flush  in  1  redirect from EX; kill ID and EX contents.
- ex_valid  out  1  ID/EX bundle valid.
- ex_ready  in  1  execute consumes bundle.
- ex_instr  out  XLEN  issued instruction.
- ex_pc  out  XLEN  issued PC.
- ex_imm  out  XLEN  sign-extended immediate from imm_gen.
- ex_rs1, ex_rs2, ex_rd  out  5  register fields.
- ex_is_load  out  1  opcode == OP_LOAD.

Behaviour:
- Reset: all registers clear immediately on rst; id_valid=0, ex_valid=0, ex_* data=0, state=RUN, bubble counter=0. if_ready=1 after reset. Reset mid-stall or mid-flush aborts the operation with no residue.
- Register use by opcode:
  - LUI/AUIPC/JAL: none.
  - JALR/LOAD/OP_IMM: rs1.
  - OP/STORE/BRANCH: rs1 and rs2.
  - Unknown opcode: none; imm = 0.
- adv_ex = !ex_valid || ex_ready.
- hazard = id_valid && ex_valid && ex_is_load && ex_rd != 0 && (uses rs1 && rs1 == ex_rd, or uses rs2 && rs2 == ex_rd). Evaluated in RUN only.
- FSM:
  - RUN: if hazard && adv_ex, then EX loads a bubble (ex_valid=0), latch lu_rd=ex_rd, cnt=LU_BUBBLES-1, ID holds. Go to LU_STALL if cnt != 0, else stay in RUN. With no hazard and adv_ex, ID moves to EX on the clock edge.
  - LU_STALL: each adv_ex cycle inserts one bubble and decrements cnt. At cnt == 0 the next adv_ex issues the ID instruction and returns to RUN.
- Issue latency: 1 cycle from the IF handshake to ID; 1 cycle from ID to ex_valid. Minimum if -> ex is 2 cycles.
- if_ready = !id_valid || (adv_ex && state==RUN && !hazard). This is a combinational path from ex_ready. ID accepts new data on the same edge it issues (full throughput, no bubbles).
- Backpressure: while ex_valid && !ex_ready, all ex_* outputs stay stable and ID holds.
- flush has priority over everything. On the next edge: id_valid=0, ex_valid=0, state=RUN, cnt=0. An IF handshake in the flush cycle is discarded. flush and hazard together: flush wins.
- ex_imm is computed from the ID register contents by imm_gen and registered into EX; it is never taken from the live input.

Decomposition:
- riscv_pkg: XLEN, opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP), and id_state_t enum {RUN, LU_STALL}.
- Instantiate the existing imm_gen as the only sub-module.
- The rs-use decode is a local function, not a module.

Test Plan:
- Streaming: addi x1,x2,0x123 at pc 0x0, then 4 more instructions back-to-back with ex_ready=1 -> ex_valid from cycle 2 every cycle; first bundle has ex_imm=0x00000123, ex_rd=1, ex_pc=0x0; no bubbles.
- Load-use, LU_BUBBLES=1: lw x5,0(x2) followed by add x6,x5,x3 -> exactly 1 cycle with ex_valid=0 between them and if_ready=0 for that cycle. With LU_BUBBLES=2 -> 2 bubbles. Same sequence with rd=x0 -> 0 bubbles.
- Backpressure: hold ex_ready=0 for 3 cycles with a valid bundle (beq, imm 0x00000008) -> ex_* stable, if_ready=0 once ID is full; ex_ready=1 resumes in order with no loss or duplication.
- Flush: assert flush for one cycle while ID and EX are full and if_valid=1 -> next cycle ex_valid=0 and id empty; the instruction offered in the flush cycle never appears on ex_*.
- Flush during LU_STALL, then a reset mid-stream -> state returns to RUN, cnt=0; on rst all outputs are 0 with no clock edge needed, and if_ready=1 after rst deasserts.
- Immediate spot checks through the pipe: jal offset 4 -> 0x00000004; lui 0x12345 -> 0x12345000; unknown opcode 0x7F -> 0x00000000 with no stall.
